// File: rtl/hash_table_fsm.sv
// Multi-cycle open-addressing hash table: lookup/insert/delete/clear with linear probing, one slot per cycle.
// Latency: 2+n cycles from accept for n probes (home-slot hit = 3); CLEAR responds the cycle after accept.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until resp_ready.
//
// Ports: clk, rst (async active-low); req_valid/req_ready/req_op/req_key/req_value request channel;
// resp_valid/resp_ready/resp_status/resp_value/resp_probes response channel;
// entry_count/tomb_count/collision_count occupancy and tuning statistics.
module hash_table_fsm #(
    parameter int    KEY_WIDTH      = 32,
    parameter int    VALUE_WIDTH    = 32,
    parameter int    TABLE_SIZE     = 16,
    parameter int    MAX_PROBE      = TABLE_SIZE,
    parameter string HASH_ALGORITHM = "FNV1A"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [KEY_WIDTH-1:0]          req_key,
    input  logic [VALUE_WIDTH-1:0]        req_value,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [1:0]                    resp_status,
    output logic [VALUE_WIDTH-1:0]        resp_value,
    output logic [$clog2(TABLE_SIZE):0]   resp_probes,
    output logic [$clog2(TABLE_SIZE):0]   entry_count,
    output logic [$clog2(TABLE_SIZE):0]   tomb_count,
    output logic [15:0]                   collision_count
);
    localparam int IDX_W = $clog2(TABLE_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] PROBE_LIM = CNT_W'(MAX_PROBE);
    localparam bit USE_MODULO = (HASH_ALGORITHM == "MODULO");

    localparam logic [1:0] S_IDLE = 2'd0, S_HASH = 2'd1, S_PROBE = 2'd2, S_RESP = 2'd3;
    localparam logic [1:0] OP_LOOKUP = 2'd0, OP_INSERT = 2'd1, OP_DELETE = 2'd2, OP_CLEAR = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_NOT_FOUND = 2'd1, ST_FULL = 2'd2, ST_UPDATED = 2'd3;

    logic [1:0]             state;
    logic [1:0]             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;
    logic [IDX_W-1:0]       home;
    logic [CNT_W-1:0]       p;
    logic                   tomb_found;
    logic [IDX_W-1:0]       tomb_idx;

    logic [KEY_WIDTH-1:0]   keys [TABLE_SIZE];
    logic [VALUE_WIDTH-1:0] vals [TABLE_SIZE];
    logic [TABLE_SIZE-1:0]  valid_bits;
    logic [TABLE_SIZE-1:0]  tomb_bits;

    function automatic logic [IDX_W-1:0] fnv_idx(input logic [KEY_WIDTH-1:0] k);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int i = 0; i < KEY_WIDTH / 8; i++) begin
            h = h ^ {24'h0, k[i*8 +: 8]};
            h = h * 32'h01000193;
        end
        return h[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] hash_idx;
    logic [IDX_W-1:0] s;
    logic             hit, empty, at_tomb, last;

    always_comb begin
        hash_idx = USE_MODULO ? key_q[IDX_W-1:0] : fnv_idx(key_q);
        s        = home + p[IDX_W-1:0];   // wraps modulo TABLE_SIZE by width
        hit      = valid_bits[s] && (keys[s] == key_q);
        empty    = !valid_bits[s] && !tomb_bits[s];
        at_tomb  = tomb_bits[s];
        last     = ((p + 1'b1) == PROBE_LIM);
    end

    // Per-slot decision for the current probe cycle.
    logic                   done, ins_en, ins_tomb, upd_en, del_en, rec_tomb;
    logic [1:0]             dec_status;
    logic [VALUE_WIDTH-1:0] dec_value;
    logic [IDX_W-1:0]       ins_idx;

    always_comb begin
        done       = 1'b0;
        dec_status = ST_OK;
        dec_value  = '0;
        ins_en     = 1'b0;
        ins_idx    = s;
        ins_tomb   = 1'b0;
        upd_en     = 1'b0;
        del_en     = 1'b0;
        rec_tomb   = 1'b0;
        case (op_q)
            OP_LOOKUP: begin
                if (hit) begin
                    done      = 1'b1;
                    dec_value = vals[s];
                end else if (empty || last) begin
                    done       = 1'b1;
                    dec_status = ST_NOT_FOUND;
                end
            end
            OP_DELETE: begin
                if (hit) begin
                    done   = 1'b1;
                    del_en = 1'b1;
                end else if (empty || last) begin
                    done       = 1'b1;
                    dec_status = ST_NOT_FOUND;
                end
            end
            default: begin  // INSERT (CLEAR never reaches PROBE)
                if (hit) begin
                    done       = 1'b1;
                    upd_en     = 1'b1;
                    dec_status = ST_UPDATED;
                end else if (empty) begin
                    done   = 1'b1;
                    ins_en = 1'b1;
                    if (tomb_found) begin
                        ins_idx  = tomb_idx;
                        ins_tomb = 1'b1;
                    end
                end else if (last) begin
                    // Out of probes: reuse the earliest tomb, which may be this very slot.
                    done = 1'b1;
                    if (tomb_found) begin
                        ins_en   = 1'b1;
                        ins_idx  = tomb_idx;
                        ins_tomb = 1'b1;
                    end else if (at_tomb) begin
                        ins_en   = 1'b1;
                        ins_tomb = 1'b1;
                    end else begin
                        dec_status = ST_FULL;
                    end
                end else begin
                    rec_tomb = at_tomb && !tomb_found;
                end
            end
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            op_q            <= OP_LOOKUP;
            key_q           <= '0;
            val_q           <= '0;
            home            <= '0;
            p               <= '0;
            tomb_found      <= 1'b0;
            tomb_idx        <= '0;
            valid_bits      <= '0;
            tomb_bits       <= '0;
            entry_count     <= '0;
            tomb_count      <= '0;
            collision_count <= '0;
            resp_status     <= ST_OK;
            resp_value      <= '0;
            resp_probes     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        key_q <= req_key;
                        val_q <= req_value;
                        if (req_op == OP_CLEAR) begin
                            valid_bits      <= '0;
                            tomb_bits       <= '0;
                            entry_count     <= '0;
                            tomb_count      <= '0;
                            collision_count <= '0;
                            resp_status     <= ST_OK;
                            resp_value      <= '0;
                            resp_probes     <= '0;
                            state           <= S_RESP;
                        end else begin
                            state <= S_HASH;
                        end
                    end
                end
                S_HASH: begin
                    home       <= hash_idx;
                    p          <= '0;
                    tomb_found <= 1'b0;
                    state      <= S_PROBE;
                end
                S_PROBE: begin
                    if (done) begin
                        resp_status <= dec_status;
                        resp_value  <= dec_value;
                        resp_probes <= p + 1'b1;
                        state       <= S_RESP;
                        if (ins_en) begin
                            valid_bits[ins_idx] <= 1'b1;
                            tomb_bits[ins_idx]  <= 1'b0;
                            entry_count         <= entry_count + 1'b1;
                            if (ins_tomb)
                                tomb_count <= tomb_count - 1'b1;
                            if (ins_idx != home && collision_count != 16'hFFFF)
                                collision_count <= collision_count + 1'b1;
                        end
                        if (del_en) begin
                            valid_bits[s] <= 1'b0;
                            tomb_bits[s]  <= 1'b1;
                            entry_count   <= entry_count - 1'b1;
                            tomb_count    <= tomb_count + 1'b1;
                        end
                    end else begin
                        p <= p + 1'b1;
                        if (rec_tomb) begin
                            tomb_found <= 1'b1;
                            tomb_idx   <= s;
                        end
                    end
                end
                default: begin  // S_RESP
                    if (resp_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Key/value storage carries no reset; the valid/tomb bits qualify it.
    always_ff @(posedge clk) begin
        if (state == S_PROBE && done) begin
            if (ins_en) begin
                keys[ins_idx] <= key_q;
                vals[ins_idx] <= val_q;
            end else if (upd_en) begin
                vals[s] <= val_q;
            end
        end
    end
endmodule
